debug_step_ctrl: RTL and testbench

//  Parametrised clock-enable generator for the pipeline CPU debug board. Replaces the
//  raw BTN3 step clock with a debounced, mode-selectable enable (halt, single-step,

---
 rtl/debug_step_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_debug_step_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl
//   Clock-enable generator for the pipeline CPU debug board. It debounces the raw
//   step button and issues one-cycle CPU advance enables in one of four modes
//   (halt, single-step, free-run, burst-N). A breakpoint hit stops free-run and
//   burst operation, and the controller then waits in BREAK until it is released.
//
//   Ports
//     CCLK      in   system clock, all state on the rising edge
//     RSTN      in   asynchronous active-low reset
//     btn_step  in   raw step button, asynchronous to CCLK
//     mode      in   00 halt, 01 single-step, 10 free-run, 11 burst-N
//     div       in   gap setting: one enable every div+1 cycles in RUN/BURST
//     burst_n   in   enables per burst; 0 makes a burst press a no-op
//     bp_hit    in   breakpoint match from the CPU (level, synchronous)
//     clr_cnt   in   synchronous clear of step_cnt
//     cpu_en    out  one-cycle CPU advance enable, registered
//     step_cnt  out  number of cpu_en pulses issued, wraps
//     busy      out  state is RUN or BURST
//     brk       out  state is BREAK
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting; single-step presses pulse directly from here
//   ST_RUN   | free-run, one enable every div+1 cycles
//   ST_BURST | issuing rem more enables, div+1 cycles apart
//   ST_BREAK | stopped by a breakpoint, a press or halt returns to IDLE

module debug_step_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int DIV_W     = 4,
  parameter int CNT_W     = 8
) (
  input  logic             CCLK,
  input  logic             RSTN,
  input  logic             btn_step,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst_n,
  input  logic             bp_hit,
  input  logic             clr_cnt,
  output logic             cpu_en,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy,
  output logic             brk
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_BREAK = 2'd3;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_RUN   = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  logic           s1, s2;
  logic           btn_db;
  logic [DBW-1:0] db_cnt;
  logic           db_done;
  logic           press;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [DIV_W-1:0] gap;
  logic             fire;
  logic             pulse;

  // Debounce: the synchronised level must differ from the accepted level for
  // DB_CYCLES consecutive cycles before it is accepted. Only a rising accept is a press.
  assign db_done = (s2 != btn_db) && (db_cnt == DB_LAST);
  assign press   = db_done && s2;

  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= btn_step;
      s2 <= s1;
      if (s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_done) begin
        btn_db <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  // Comparing with >= means lowering div mid-run fires on the next cycle
  // instead of waiting for the gap counter to wrap.
  assign fire = (gap >= div);

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    pulse     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode == MODE_STEP && press) begin
          pulse = 1'b1;
        end else if (mode == MODE_RUN) begin
          state_nxt = ST_RUN;
        end else if (mode == MODE_BURST && press && burst_n != '0) begin
          state_nxt = ST_BURST;
          rem_nxt   = burst_n;
        end
      end
      ST_RUN: begin
        if (bp_hit) begin
          state_nxt = ST_BREAK;
        end else if (mode != MODE_RUN) begin
          state_nxt = ST_IDLE;
        end else if (fire) begin
          pulse = 1'b1;
        end
      end
      ST_BURST: begin
        if (bp_hit) begin
          state_nxt = ST_BREAK;
          rem_nxt   = '0;
        end else if (mode != MODE_BURST) begin
          state_nxt = ST_IDLE;
          rem_nxt   = '0;
        end else if (fire) begin
          pulse   = 1'b1;
          rem_nxt = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        // A press here only releases the break; it never advances the CPU.
        if (press || mode == MODE_HALT) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        rem_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ST_IDLE;
      rem      <= '0;
      gap      <= '0;
      cpu_en   <= 1'b0;
      step_cnt <= '0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      cpu_en <= pulse;

      // Restart the gap on every pulse and on every state entry so that the
      // first RUN/BURST pulse lands div+1 edges after entry.
      if (pulse || state_nxt != state) begin
        gap <= '0;
      end else if (state == ST_RUN || state == ST_BURST) begin
        gap <= gap + DIV_W'(1);
      end else begin
        gap <= '0;
      end

      if (clr_cnt) begin
        step_cnt <= '0;
      end else if (pulse) begin
        step_cnt <= step_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_BURST);
  assign brk  = (state == ST_BREAK);

endmodule

// File: tb/tb_debug_step_ctrl.sv
// tb_debug_step_ctrl
//   Drives debug_step_ctrl with directed scenarios and random segments and
//   compares every cycle against a behavioural model of the step controller.

module tb_debug_step_ctrl;

  localparam int DB    = 4;
  localparam int DIV_W = 4;
  localparam int CNT_W = 8;

  logic             CCLK = 1'b0;
  logic             RSTN = 1'b1;
  logic             btn_step = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [DIV_W-1:0] div = '0;
  logic [CNT_W-1:0] burst_n = '0;
  logic             bp_hit = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             cpu_en;
  logic [CNT_W-1:0] step_cnt;
  logic             busy;
  logic             brk;

  debug_step_ctrl #(.DB_CYCLES(DB), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .CCLK     (CCLK),
    .RSTN     (RSTN),
    .btn_step (btn_step),
    .mode     (mode),
    .div      (div),
    .burst_n  (burst_n),
    .bp_hit   (bp_hit),
    .clr_cnt  (clr_cnt),
    .cpu_en   (cpu_en),
    .step_cnt (step_cnt),
    .busy     (busy),
    .brk      (brk)
  );

  always #5 CCLK = ~CCLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: the button is tracked as a delayed sample stream and a
  // run length of disagreeing samples; pacing is the number of edges since the
  // last pulse or mode entry.
  typedef enum int {M_IDLE, M_RUN, M_BURST, M_BREAK} mstate_t;
  mstate_t m_st;
  int m_s1, m_s2, m_lvl, m_run, m_since, m_rem, m_cnt, m_en;
  int obs_pulses;
  int cyc;
  int first_pulse_cyc;

  task automatic model_reset();
    m_st = M_IDLE;
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
    m_since = 0; m_rem = 0; m_cnt = 0; m_en = 0;
  endtask

  task automatic step();
    int      run_now;
    bit      press, fire, pulse;
    mstate_t nxt;
    int      rem_n;
    run_now = (m_s2 != m_lvl) ? m_run + 1 : 0;
    press   = (run_now == DB) && (m_s2 == 1);
    fire    = (m_since >= int'(div));
    pulse   = 1'b0;
    nxt     = m_st;
    rem_n   = m_rem;
    case (m_st)
      M_IDLE: begin
        if (mode == 2'b01 && press) pulse = 1'b1;
        else if (mode == 2'b10) nxt = M_RUN;
        else if (mode == 2'b11 && press && burst_n != 0) begin
          nxt = M_BURST; rem_n = int'(burst_n);
        end
      end
      M_RUN: begin
        if (bp_hit) nxt = M_BREAK;
        else if (mode != 2'b10) nxt = M_IDLE;
        else if (fire) pulse = 1'b1;
      end
      M_BURST: begin
        if (bp_hit) begin nxt = M_BREAK; rem_n = 0; end
        else if (mode != 2'b11) begin nxt = M_IDLE; rem_n = 0; end
        else if (fire) begin
          pulse = 1'b1;
          rem_n = m_rem - 1;
          if (rem_n == 0) nxt = M_IDLE;
        end
      end
      default: begin
        if (press || mode == 2'b00) nxt = M_IDLE;
      end
    endcase

    @(posedge CCLK);
    #1;
    cyc++;
    if (run_now == DB) begin m_lvl = m_s2; m_run = 0; end
    else m_run = run_now;
    m_s2 = m_s1;
    m_s1 = int'(btn_step);
    if (pulse || nxt != m_st) m_since = 0;
    else if (nxt == M_RUN || nxt == M_BURST) m_since = m_since + 1;
    else m_since = 0;
    m_st  = nxt;
    m_rem = rem_n;
    m_en  = int'(pulse);
    if (clr_cnt) m_cnt = 0;
    else if (pulse) m_cnt = (m_cnt + 1) % (1 << CNT_W);

    if (cpu_en) begin
      obs_pulses++;
      if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
    end
    check_val("cpu_en", int'(cpu_en), m_en);
    check_val("step_cnt", int'(step_cnt), m_cnt);
    check_val("busy", int'(busy), (m_st == M_RUN || m_st == M_BURST) ? 1 : 0);
    check_val("brk", int'(brk), (m_st == M_BREAK) ? 1 : 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called just after an active edge: reset asynchronously, check the outputs
  // clear before the next edge, then release.
  task automatic do_reset();
    btn_step = 1'b0;
    bp_hit   = 1'b0;
    clr_cnt  = 1'b0;
    RSTN     = 1'b0;
    #2;
    check_val("rst_cpu_en", int'(cpu_en), 0);
    check_val("rst_step_cnt", int'(step_cnt), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_brk", int'(brk), 0);
    model_reset();
    @(posedge CCLK);
    @(posedge CCLK);
    #1;
    RSTN = 1'b1;
  endtask

  initial begin
    int len;
    cyc = 0;
    first_pulse_cyc = -1;
    obs_pulses = 0;
    #1;
    do_reset();

    // Single-step: held press gives one pulse, in the cycle after edge 2+DB.
    mode = 2'b01;
    btn_step = 1'b1;
    cyc = 0; first_pulse_cyc = -1; obs_pulses = 0;
    steps(10);
    btn_step = 1'b0;
    steps(10);
    check_val("step_first_edge", first_pulse_cyc, 2 + DB);
    check_val("step_pulses", obs_pulses, 1);
    check_val("step_cnt_after_press", int'(step_cnt), 1);

    // Short glitch, then a bounce that settles high: one pulse only.
    obs_pulses = 0;
    btn_step = 1'b1; steps(2);
    btn_step = 1'b0; steps(6);
    btn_step = 1'b1; steps(1);
    btn_step = 1'b0; steps(1);
    btn_step = 1'b1; steps(12);
    btn_step = 1'b0; steps(10);
    check_val("bounce_pulses", obs_pulses, 1);

    // Free-run, div=3: five pulses in 20 cycles after entry; then div=0.
    mode = 2'b00; clr_cnt = 1'b1; steps(1); clr_cnt = 1'b0;
    div = 4'd3; mode = 2'b10;
    steps(21);
    check_val("run_div3_cnt", int'(step_cnt), 5);
    div = 4'd0;
    steps(8);
    check_val("run_div0_cnt", int'(step_cnt), 13);
    mode = 2'b00; steps(2);

    // Burst of 5, div=1; then burst_n=0 ignores the press.
    mode = 2'b11; burst_n = 8'd5; div = 4'd1; obs_pulses = 0;
    btn_step = 1'b1; steps(8);
    btn_step = 1'b0; steps(22);
    check_val("burst5_pulses", obs_pulses, 5);
    burst_n = 8'd0; obs_pulses = 0;
    btn_step = 1'b1; steps(8);
    btn_step = 1'b0; steps(10);
    check_val("burst0_pulses", obs_pulses, 0);

    // Breakpoint on a fire cycle in free-run, released by a press.
    mode = 2'b10; div = 4'd3; obs_pulses = 0;
    steps(4);
    bp_hit = 1'b1; steps(1); bp_hit = 1'b0;
    check_val("bp_no_pulse", obs_pulses, 0);
    check_val("bp_brk", int'(brk), 1);
    check_val("bp_busy", int'(busy), 0);
    mode = 2'b01;
    btn_step = 1'b1; steps(8);
    btn_step = 1'b0; steps(6);
    check_val("bp_release_pulses", obs_pulses, 0);
    check_val("bp_released", int'(brk), 0);

    // Counter wrap and clear-versus-increment.
    mode = 2'b00; clr_cnt = 1'b1; steps(1); clr_cnt = 1'b0;
    mode = 2'b10; div = 4'd0;
    steps(256);
    check_val("cnt_at_max", int'(step_cnt), 255);
    steps(1);
    check_val("cnt_wrap", int'(step_cnt), 0);
    steps(3);
    clr_cnt = 1'b1; steps(1); clr_cnt = 1'b0;
    check_val("clr_beats_inc", int'(step_cnt), 0);

    // Reset in the middle of a long burst, then quiet afterwards.
    mode = 2'b00; steps(2);
    mode = 2'b11; burst_n = 8'd50; div = 4'd2;
    btn_step = 1'b1; steps(12);
    check_val("burst_busy", int'(busy), 1);
    do_reset();
    obs_pulses = 0;
    steps(20);
    check_val("post_reset_quiet", obs_pulses, 0);

    // Random segments against the model.
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 14) == 0) do_reset();
      mode    = 2'($urandom_range(0, 3));
      div     = 4'($urandom_range(0, 5));
      burst_n = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      len     = $urandom_range(5, 40);
      for (int c = 0; c < len; c++) begin
        bp_hit  = ($urandom_range(0, 19) == 0);
        clr_cnt = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 4) == 0) btn_step = ~btn_step;
        step();
      end
    end
    bp_hit = 1'b0; clr_cnt = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
